// File: rtl/load_store_unit.sv
// load_store_unit: sequences load/store requests onto the data memory port.
// Optional MISALIGN_TRAP_EN: flag misaligned requests instead of splitting them.
module load_store_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] RDATA_RST = 32'h0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic              resp_misaligned,
`endif
  output logic              mem_we,
  output logic [1:0]        mem_byteacc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    SPLIT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              sz_b, sz_h;
  logic              mis, last;
  logic [4:0]        sh;
  logic [31:0]       lane, pair_lo;
  logic [7:0]        wbyte;
  logic [ADDR_W-1:0] base;

  function automatic logic misal(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic b, h;
    b = (f3[1:0] == 2'b00);
    h = (f3[1:0] == 2'b01);
    return (h && a[0]) || (!b && !h && (a != 2'b00));
  endfunction

  // Memory returns raw lanes; sub-word loads are extended here.
  function automatic logic [31:0] extend(
    input logic [31:0] d,
    input logic [2:0]  f3
  );
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'h0, d[7:0]};
      3'b101:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign sz_b    = (f3_q[1:0] == 2'b00);
  assign sz_h    = (f3_q[1:0] == 2'b01);
  assign mis     = misal(f3_q, addr_q[1:0]);
  assign last    = (cnt_q == (sz_h ? 2'd1 : 2'd3));
  assign sh      = {addr_q[1:0], 3'b000};
  assign lane    = mem_rdata >> sh;
  assign pair_lo = 32'({mem_rdata, lo_q} >> sh);
  assign wbyte   = 8'(wdata_q >> {cnt_q, 3'b000});
  assign base    = {addr_q[ADDR_W-1:2], 2'b00};

  assign resp_rdata = rdata_q;

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  assign resp_misaligned = mis_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lo_d        = lo_q;
    rdata_d     = rdata_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_we      = 1'b0;
    mem_byteacc = 2'b00;
    mem_addr    = base;
    mem_wdata   = '0;
`ifdef MISALIGN_TRAP_EN
    mis_d       = mis_q;
`endif
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_d   = '0;
          state_d = ACCESS;
`ifdef MISALIGN_TRAP_EN
          mis_d = misal(req_funct3, req_addr[1:0]);
          if (mis_d) begin
            state_d = DONE;
            rdata_d = RDATA_RST;
          end
`endif
        end
      end
      ACCESS: begin
        if (we_q) begin
          mem_we   = 1'b1;
          mem_addr = addr_q;
          if (mis) begin
            mem_byteacc = 2'b01;
            mem_wdata   = {24'h0, wbyte};
            cnt_d       = 2'd1;
            state_d     = SPLIT;
          end else begin
            mem_wdata = wdata_q;
            state_d   = DONE;
            unique case (1'b1)
              sz_b:    mem_byteacc = 2'b01;
              sz_h:    mem_byteacc = 2'b10;
              default: mem_byteacc = 2'b00;
            endcase
          end
        end else if (mis) begin
          lo_d    = mem_rdata;
          state_d = SPLIT;
        end else begin
          rdata_d = extend(lane, f3_q);
          state_d = DONE;
        end
      end
      SPLIT: begin
        if (we_q) begin
          mem_we      = 1'b1;
          mem_byteacc = 2'b01;
          mem_addr    = addr_q + ADDR_W'(cnt_q);
          mem_wdata   = {24'h0, wbyte};
          cnt_d       = cnt_q + 2'd1;
          state_d     = last ? DONE : SPLIT;
        end else begin
          mem_addr = base + ADDR_W'(4);
          rdata_d  = extend(pair_lo, f3_q);
          state_d  = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      rdata_q <= RDATA_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      if (req_valid && req_ready) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mis_q <= 1'b0;
    else          mis_q <= mis_d;
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a byte memory model.
// Builds with or without MISALIGN_TRAP_EN.
module tb_load_store_unit;

  localparam logic [31:0] RST = 32'h5A5A_A5A5;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
`ifdef MISALIGN_TRAP_EN
  logic        resp_misaligned;
`endif
  logic        mem_we;
  logic [1:0]  mem_byteacc;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDR_W   (32),
    .RDATA_RST(RST)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
`ifdef MISALIGN_TRAP_EN
    .resp_misaligned(resp_misaligned),
`endif
    .mem_we         (mem_we),
    .mem_byteacc    (mem_byteacc),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // 4 KiB memory, aliased over the full address space
  logic [7:0]  m [0:4095];
  logic        pl_we = 1'b0;
  logic [11:0] pl_a  = '0;
  logic [31:0] pl_d  = '0;
  logic [11:0] ra;

  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  ba;
    logic [31:0] d;
  } wr_t;
  wr_t wlog[$];

  assign ra        = {mem_addr[11:2], 2'b00};
  assign mem_rdata = {m[ra+12'd3], m[ra+12'd2], m[ra+12'd1], m[ra]};

  always @(posedge clk) begin
    if (pl_we)
      for (int i = 0; i < 4; i++) m[pl_a+12'(i)] <= pl_d[8*i+:8];
    if (mem_we) begin
      wlog.push_back('{mem_addr, mem_byteacc, mem_wdata});
      case (mem_byteacc)
        2'b01: m[mem_addr[11:0]] <= mem_wdata[7:0];
        2'b10: begin
          m[mem_addr[11:0]]       <= mem_wdata[7:0];
          m[mem_addr[11:0]+12'd1] <= mem_wdata[15:8];
        end
        default:
          for (int i = 0; i < 4; i++)
            m[mem_addr[11:0]+12'(i)] <= mem_wdata[8*i+:8];
      endcase
    end
  end

  function automatic logic [31:0] rdw(input logic [11:0] a);
    return {m[a+12'd3], m[a+12'd2], m[a+12'd1], m[a]};
  endfunction

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        mis;
    int unsigned cyc;
  } exp_t;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] last_ld = RST;

  always @(negedge clk) begin
    if (reset_n && resp_valid) begin
      if (sbq.size() == 0) begin
        check("spurious_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check({mon_e.tag, "_rd"}, resp_rdata, mon_e.rdata);
        check({mon_e.tag, "_lat"}, cyc, mon_e.cyc);
`ifdef MISALIGN_TRAP_EN
        check({mon_e.tag, "_mis"}, 32'(resp_misaligned), 32'(mon_e.mis));
`endif
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // lat counts cycles from the accept cycle to the resp_valid cycle
  task automatic req(
    input string       tag,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] ld_exp,
    input int          lat,
    input bit          mis
  );
    exp_t e;
    e.tag   = tag;
    e.rdata = we ? last_ld : ld_exp;
    e.mis   = TRAP && mis;
    if (TRAP && mis) begin
      e.rdata = RST;
      lat     = 1;
    end
    last_ld = e.rdata;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    e.cyc = cyc + unsigned'(lat);
    sbq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      check({tag, "_timeout"}, 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic op(
    input string       tag,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] ld_exp,
    input int          lat,
    input bit          mis
  );
    req(tag, we, f3, a, wd, ld_exp, lat, mis);
    wait_idle(tag);
  endtask

  logic [31:0] wd;
  logic [31:0] ra0;
  int          need, seen, nexp;

  initial begin
    #1 reset_n = 1'b0;
    #2;
    check("rst_rdy", 32'(req_ready), 32'd1);
    check("rst_vld", 32'(resp_valid), 32'd0);
    check("rst_rd", resp_rdata, RST);
    check("rst_we", 32'(mem_we), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    preload(12'h100, 32'h8899_AABB);
    op("lb",   1'b0, 3'b000, 32'h103, 0, 32'hFFFF_FF88, 2, 1'b0);
    op("lbu",  1'b0, 3'b100, 32'h103, 0, 32'h0000_0088, 2, 1'b0);
    op("lh",   1'b0, 3'b001, 32'h100, 0, 32'hFFFF_AABB, 2, 1'b0);
    op("lhu",  1'b0, 3'b101, 32'h102, 0, 32'h0000_8899, 2, 1'b0);
    op("lw",   1'b0, 3'b010, 32'h100, 0, 32'h8899_AABB, 2, 1'b0);
    op("lw110", 1'b0, 3'b110, 32'h100, 0, 32'h8899_AABB, 2, 1'b0);

    wlog.delete();
    op("sh", 1'b1, 3'b001, 32'h102, 32'h0000_1234, 0, 2, 1'b0);
    check("sh_nwr", 32'(wlog.size()), 32'd1);
    for (int i = 0; i < wlog.size() && i < 1; i++) begin
      check("sh_addr", wlog[i].a, 32'h102);
      check("sh_ba", 32'(wlog[i].ba), 32'd2);
      check("sh_data", wlog[i].d, 32'h0000_1234);
    end
    check("sh_mem", rdw(12'h100), 32'h1234_AABB);
    op("sb", 1'b1, 3'b000, 32'h101, 32'hFFFF_FF77, 0, 2, 1'b0);
    check("sb_mem", rdw(12'h100), 32'h1234_77BB);

    preload(12'h100, 32'h4433_2211);
    preload(12'h104, 32'h8877_6655);
    op("lw_mis",  1'b0, 3'b010, 32'h101, 0, 32'h5544_3322, 3, 1'b1);
    op("lh_mis",  1'b0, 3'b001, 32'h103, 0, 32'h0000_5544, 3, 1'b1);
    op("lh_odd",  1'b0, 3'b001, 32'h105, 0, 32'h0000_7766, 3, 1'b1);
    op("lh_al",   1'b0, 3'b001, 32'h106, 0, 32'hFFFF_8877, 2, 1'b0);

    // misaligned sw with ignored request pulses while busy
    wlog.delete();
    wd = 32'hDDCC_BBAA;
    req("sw_mis", 1'b1, 3'b010, 32'h103, wd, 0, 5, 1'b1);
    for (int i = 0; i < (TRAP ? 0 : 4); i++) begin
      check("sw_busy_rdy", 32'(req_ready), 32'd0);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h100;
      @(negedge clk);
    end
    req_valid = 1'b0;
    wait_idle("sw_mis");
    nexp = TRAP ? 0 : 4;
    check("sw_nwr", 32'(wlog.size()), 32'(nexp));
    for (int i = 0; i < wlog.size() && i < 4; i++) begin
      check("sw_addr", wlog[i].a, 32'h103 + 32'(i));
      check("sw_ba", 32'(wlog[i].ba), 32'd1);
      check("sw_data", wlog[i].d, (wd >> (8 * i)) & 32'hFF);
    end
    check("sw_m100", rdw(12'h100), TRAP ? 32'h4433_2211 : 32'hAA33_2211);
    check("sw_m104", rdw(12'h104), TRAP ? 32'h8877_6655 : 32'h88DD_CCBB);

    wlog.delete();
    wd = 32'h0000_BEEF;
    op("sh_wrap", 1'b1, 3'b001, 32'hFFFF_FFFF, wd, 0, 3, 1'b1);
    nexp = TRAP ? 0 : 2;
    check("shw_nwr", 32'(wlog.size()), 32'(nexp));
    for (int i = 0; i < wlog.size() && i < 2; i++) begin
      check("shw_addr", wlog[i].a, 32'hFFFF_FFFF + 32'(i));
      check("shw_data", wlog[i].d, (wd >> (8 * i)) & 32'hFF);
    end

    preload(12'hFFC, 32'hA1B2_C3D4);
    preload(12'h000, 32'h1122_3344);
    op("lw_wrap", 1'b0, 3'b010, 32'hFFFF_FFFE, 0, 32'h3344_A1B2, 3, 1'b1);
    op("lw_al", 1'b0, 3'b010, 32'h100, 0,
       TRAP ? 32'h4433_2211 : 32'hAA33_2211, 2, 1'b0);

    // reset during a store write cycle
    wlog.delete();
    ra0  = TRAP ? 32'h100 : 32'h103;
    need = TRAP ? 1 : 2;
    seen = 0;
    req("rst_sw", 1'b1, 3'b010, ra0, 32'h0102_0304, 0, 5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (mem_we) seen++;
      if (seen >= need) break;
      @(posedge clk);
      #1;
    end
    check("rst_pre_we", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_we", 32'(mem_we), 32'd0);
    check("rst_mid_vld", 32'(resp_valid), 32'd0);
    check("rst_mid_rd", resp_rdata, RST);
    sbq.delete();
    last_ld = RST;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_rdy_after", 32'(req_ready), 32'd1);
    check("rst_nwr", 32'(wlog.size()), 32'(need - 1));
    op("lb_after", 1'b0, 3'b100, 32'h100, 0, 32'h0000_0011, 2, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
